// File: rtl/regfile_pkg.sv
// Shared types for the parametrised integer register file.
// Optional build macro: REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

  localparam int RF_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry writing zero after reset or clear_req.
// Drives busy so the pipeline stalls for the whole sweep.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PENULT = ADDR_W'(DEPTH - 2);

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_ptr;

  // clear_done is set one edge early so it lines up with the last write
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RF_CLEAR;
      clr_ptr    <= '0;
      clear_done <= 1'b0;
    end else begin
      unique case (state)
        RF_IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state   <= RF_CLEAR;
            clr_ptr <= '0;
          end
        end
        RF_CLEAR: begin
          clr_ptr    <= clr_ptr + ADDR_W'(1);
          clear_done <= (clr_ptr == PENULT);
          if (clr_ptr == LAST) begin
            state      <= RF_IDLE;
            clear_done <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy     = (state == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2R1W register file with optional hard zero and clear sequencer.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int DEPTH     = 32,
  parameter  int HARD_ZERO = 1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_ADDR);
  localparam logic              HZ   = (HARD_ZERO != 0);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              zero_1;
  logic              zero_2;

  regfile_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr)
  );

  assign user_we = RegWrite && !busy
                && !(HZ && (write_addr == ZERO));
  assign we      = clr_we || user_we;
  assign waddr   = clr_we ? clr_addr : write_addr;
  assign wdata   = clr_we ? '0 : write_data;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign zero_1 = busy || (HZ && (read_addr_1 == ZERO));
  assign zero_2 = busy || (HZ && (read_addr_2 == ZERO));

  always_comb begin
    read_data_1 = mem[read_addr_1];
`ifdef REGFILE_BYPASS_EN
    if (user_we && (write_addr == read_addr_1))
      read_data_1 = write_data;
`endif
    if (zero_1) read_data_1 = '0;
  end

  always_comb begin
    read_data_2 = mem[read_addr_2];
`ifdef REGFILE_BYPASS_EN
    if (user_we && (write_addr == read_addr_2))
      read_data_2 = write_data;
`endif
    if (zero_2) read_data_2 = '0;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the core's 32x32 integer register file.
- Adds configurable width and depth, and a hard-wired zero register that can be disabled.
- Adds a synchronous reset that starts a hardware clear sequencer, plus a software clear request and a busy flag that the pipeline uses to stall.
- Sits between the decode stage (two async read ports) and the writeback stage (one sync write port).

Parameters:
- DATA_W, 32, width of each register in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- HARD_ZERO, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- read_addr_1  in  ADDR_W  read port 1 address.
- read_addr_2  in  ADDR_W  read port 2 address.
- read_data_1  out  DATA_W  read port 1 data, combinational.
- read_data_2  out  DATA_W  read port 2 data, combinational.
- RegWrite  in  1  write enable.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- clear_req  in  1  single-cycle pulse; starts a full clear.
- busy  out  1  high while the clear sequencer runs.
- clear_done  out  1  one-cycle pulse on the last clear write.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Storage: DEPTH x DATA_W array with no initial block; all contents are defined only by the clear sequence.
- FSM states are IDLE and CLEAR; the counter clr_ptr is ADDR_W bits wide.
- Reset:
  - rst=1 at an edge forces state=CLEAR, clr_ptr=0, clear_done=0.
  - busy is driven from state, so it is 1 in the cycle after reset.
  - rst asserted mid-clear restarts at clr_ptr=0.
- CLEAR state:
  - Each cycle writes 0 to entry clr_ptr, then clr_ptr increments.
  - When clr_ptr==DEPTH-1: write 0, assert clear_done for that cycle, next state=IDLE.
  - A full clear takes exactly DEPTH cycles; busy is high for DEPTH cycles.
- IDLE state:
  - clear_req=1 moves to CLEAR with clr_ptr=0 on the next edge.
  - clear_req is ignored while already in CLEAR; a clear is never extended.
- Writes:
  - In IDLE, RegWrite=1 writes write_data to write_addr at the rising edge.
  - In CLEAR, RegWrite is ignored and the write is dropped. The pipeline must stall on busy.
  - RegWrite together with clear_req in IDLE: the write happens, then the clear starts next cycle, so the write is lost after the clear.
  - With HARD_ZERO=1, a write to address 0 is suppressed.
- Reads:
  - Combinational: read_data_n = array[read_addr_n].
  - Forced to 0 if HARD_ZERO=1 and read_addr_n==0.
  - Forced to 0 whenever busy=1, for all addresses.
  - Both ports may read the same address.
- Read/write collision in the same cycle: see the optional feature.
- Arithmetic: clr_ptr wraps naturally at DEPTH; no out-of-range addresses exist because DEPTH is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If RegWrite=1, state is IDLE, write_addr==read_addr_n and the address is not a suppressed zero, then read_data_n=write_data combinationally, in the same cycle.
  - This gives write-before-read semantics for single-cycle writeback.
- Not defined: a same-cycle read returns the old array value; the new value is visible from the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - typedef enum rf_state_t {RF_IDLE, RF_CLEAR};
  - localparam RF_ZERO_ADDR=0;
  - function clog2 helper, if the tool lacks $clog2.
- Sub-module regfile_clear_seq (FSM plus clr_ptr):
  - Outputs busy, clear_done, clr_we, clr_addr.
  - The top muxes clr_we/clr_addr/0 against the user write port.

Test Plan:
- Reset clear:
  - Pulse rst for 1 cycle, DEPTH=32 -> busy=1 for exactly 32 cycles.
  - clear_done pulses on the 32nd cycle.
  - All reads return 0x00000000 throughout.
  - RegWrite to addr 5 during busy leaves addr 5 at 0 afterwards.
- Write/read and zero register:
  - Write 0xDEADBEEF to addr 7 -> next cycle read_data_1 = 0xDEADBEEF at addr 7.
  - Write 0x12345678 to addr 0 with HARD_ZERO=1 -> reads of addr 0 give 0.
  - Same write with HARD_ZERO=0 -> reads of addr 0 give 0x12345678.
- Bypass:
  - Write 0xA5A5A5A5 to addr 3 while read_addr_2=3 in the same cycle.
  - With REGFILE_BYPASS_EN -> read_data_2 = 0xA5A5A5A5 that cycle.
  - Without REGFILE_BYPASS_EN -> old value that cycle, 0xA5A5A5A5 the next cycle.
- Software clear:
  - Fill all entries with their index, then pulse clear_req -> busy high next cycle for DEPTH cycles.
  - Afterwards all entries read 0.
  - A second clear_req mid-clear does not lengthen busy.
- Reset mid-clear:
  - Assert rst at clr_ptr=10 -> clr_ptr restarts at 0; busy stays high for a further 32 cycles.
  - clear_done fires only once, at the end.
- Parametrisation:
  - DATA_W=64, DEPTH=16 -> clear takes 16 cycles.
  - Writing 0xFFFF_FFFF_FFFF_FFFF to addr 15 then reading it returns the full 64-bit value.
